// File: rtl/ysyx_25020037_ifu_pf_if.sv
// Bundle between the prefetching IFU and its surroundings: redirect, IDU queue port,
// I-cache lookup/refill, and the AXI4-Lite read channels.
interface ysyx_25020037_ifu_pf_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_fault;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_hit;
    logic [INST_W-1:0] ic_data;
    logic              ic_fill;
    logic [ADDR_W-1:0] ic_fill_addr;
    logic [INST_W-1:0] ic_fill_data;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [INST_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    // The IFU is the master of this bundle.
    modport master (
        input  redirect_valid, redirect_pc, out_ready, ic_hit, ic_data,
               arready, rdata, rresp, rvalid,
        output out_valid, out_pc, out_inst, out_fault, ic_req, ic_addr,
               ic_fill, ic_fill_addr, ic_fill_data, araddr, arvalid, rready
    );

    modport slave (
        output redirect_valid, redirect_pc, out_ready, ic_hit, ic_data,
               arready, rdata, rresp, rvalid,
        input  out_valid, out_pc, out_inst, out_fault, ic_req, ic_addr,
               ic_fill, ic_fill_addr, ic_fill_data, araddr, arvalid, rready
    );
endinterface

// File: rtl/ysyx_25020037_ifu_pf.sv
// Prefetching fetch unit: sequential PC walk, I-cache lookup, AXI4-Lite miss path
// with cache refill, and a small fetch queue towards the IDU.
module ysyx_25020037_ifu_pf #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_25020037_ifu_pf_if.master  bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FQ_DEPTH);

    typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, DROP, HALT} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc, pc_next;
    logic              drop_pending, drop_next;
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q, rready_q;
    logic              fill_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [INST_W-1:0] fill_data_q;

    logic [ADDR_W-1:0] pc_buf    [FQ_DEPTH];
    logic [INST_W-1:0] inst_buf  [FQ_DEPTH];
    logic              fault_buf [FQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              ic_req, ar_load, fill_set;
    logic [ADDR_W-1:0] ic_addr;
    logic              push, push_fault, pop;
    logic [INST_W-1:0] push_inst;

    assign pop = (count != '0) && bus.out_ready && !bus.redirect_valid;

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        drop_next  = drop_pending;
        ic_req     = 1'b0;
        ic_addr    = fetch_pc;
        ar_load    = 1'b0;
        fill_set   = 1'b0;
        push       = 1'b0;
        push_fault = 1'b0;
        push_inst  = bus.ic_data;
        case (state)
            IDLE: begin
                if (!bus.redirect_valid && !rst && count < FULL) begin
                    ic_req     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.redirect_valid) begin
                    state_next = IDLE;
                end else if (bus.ic_hit) begin
                    push    = 1'b1;
                    pc_next = fetch_pc + ADDR_W'(4);
                    ic_addr = pc_next;
                    // Back-to-back lookups only while the push leaves room.
                    if ((count + CNT_W'(1)) < FULL) begin
                        ic_req = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    ar_load    = 1'b1;
                    state_next = AR;
                end
            end
            AR: begin
                if (bus.redirect_valid) drop_next = 1'b1;
                // A flushed read must still complete its address beat and be drained.
                if (bus.arready) begin
                    state_next = (bus.redirect_valid || drop_pending) ? DROP : R;
                    drop_next  = 1'b0;
                end
            end
            R: begin
                if (bus.rvalid) begin
                    if (bus.redirect_valid) begin
                        state_next = IDLE;
                    end else if (bus.rresp == 2'b00) begin
                        push       = 1'b1;
                        push_inst  = bus.rdata;
                        fill_set   = 1'b1;
                        pc_next    = fetch_pc + ADDR_W'(4);
                        state_next = IDLE;
                    end else begin
                        push       = 1'b1;
                        push_inst  = bus.rdata;
                        push_fault = 1'b1;
                        state_next = HALT;
                    end
                end else if (bus.redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.rvalid) state_next = IDLE;
            end
            HALT: begin
                if (bus.redirect_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.redirect_valid) pc_next = bus.redirect_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            drop_pending <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            fill_q       <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
        end else begin
            state        <= state_next;
            fetch_pc     <= pc_next;
            drop_pending <= drop_next;
            if (ar_load) araddr_q <= fetch_pc;
            arvalid_q    <= (state_next == AR);
            rready_q     <= (state_next == R) || (state_next == DROP);
            fill_q       <= fill_set;
            if (fill_set) begin
                fill_addr_q <= fetch_pc;
                fill_data_q <= bus.rdata;
            end
        end
    end

    // Redirect empties the queue outright, overriding any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_buf[i]    <= '0;
                inst_buf[i]  <= '0;
                fault_buf[i] <= 1'b0;
            end
        end else if (bus.redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_buf[wr_ptr]    <= fetch_pc;
                inst_buf[wr_ptr]  <= push_inst;
                fault_buf[wr_ptr] <= push_fault;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.out_valid    = (count != '0);
    assign bus.out_pc       = pc_buf[rd_ptr];
    assign bus.out_inst     = inst_buf[rd_ptr];
    assign bus.out_fault    = fault_buf[rd_ptr];
    assign bus.ic_req       = ic_req;
    assign bus.ic_addr      = ic_addr;
    assign bus.ic_fill      = fill_q;
    assign bus.ic_fill_addr = fill_addr_q;
    assign bus.ic_fill_data = fill_data_q;
    assign bus.araddr       = araddr_q;
    assign bus.arvalid      = arvalid_q;
    assign bus.rready       = rready_q;
endmodule

// File: tb/tb_ysyx_25020037_ifu_pf.sv
// Directed bench for the prefetching IFU: hit streaming, miss/refill, full queue,
// redirect while reading, bus-error halt, and redirect racing a push and a pop.
module tb_ysyx_25020037_ifu_pf;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ysyx_25020037_ifu_pf_if #(.ADDR_W(32), .INST_W(32)) bus ();

    ysyx_25020037_ifu_pf #(
        .ADDR_W(32), .INST_W(32), .FQ_DEPTH(4), .RESET_PC(32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rv, input logic [31:0] rpc, input logic ordy,
                                  input logic hit, input logic [31:0] idata, input logic arrdy,
                                  input logic rvld, input logic [1:0] resp, input logic [31:0] rd);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = ordy;
        bus.ic_hit         = hit;
        bus.ic_data        = idata;
        bus.arready        = arrdy;
        bus.rvalid         = rvld;
        bus.rresp          = resp;
        bus.rdata          = rd;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("rst_out_valid", bus.out_valid, 0);
        check_output("rst_out_fault", bus.out_fault, 0);
        check_output("rst_ic_req", bus.ic_req, 0);
        check_output("rst_ic_fill", bus.ic_fill, 0);
        check_output("rst_arvalid", bus.arvalid, 0);
        check_output("rst_rready", bus.rready, 0);
        check_output("rst_araddr", bus.araddr, 0);
        check_output("rst_out_pc", bus.out_pc, 0);
        check_output("rst_out_inst", bus.out_inst, 0);
        check_output("rst_fill_addr", bus.ic_fill_addr, 0);
        check_output("rst_fill_data", bus.ic_fill_data, 0);

        // Streaming hits with the IDU always ready
        do_reset();
        apply_stimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        check_output("hit_req0", bus.ic_req, 1);
        check_output("hit_addr0", bus.ic_addr, 64'h8000_0000);
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 1, 1, 32'h1000 + i, 0, 0, 0, 0);
            check_output("hit_req", bus.ic_req, 1);
            check_output("hit_addr", bus.ic_addr, 64'h8000_0000 + 4 * (i + 1));
            if (i >= 1) begin
                check_output("hit_valid", bus.out_valid, 1);
                check_output("hit_pc", bus.out_pc, 64'h8000_0000 + 4 * (i - 1));
                check_output("hit_inst", bus.out_inst, 64'h1000 + (i - 1));
            end else begin
                check_output("hit_valid0", bus.out_valid, 0);
            end
            next_cycle();
        end

        // Miss, AXI read, refill
        do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("miss_req", bus.ic_req, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("miss_no_req", bus.ic_req, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("miss_arvalid", bus.arvalid, 1);
        check_output("miss_araddr", bus.araddr, 64'h8000_0000);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("miss_arvalid_hold", bus.arvalid, 1);
        check_output("miss_araddr_hold", bus.araddr, 64'h8000_0000);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("miss_rready", bus.rready, 1);
        check_output("miss_arvalid_drop", bus.arvalid, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 2'b00, 32'h0000_0413);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("fill", bus.ic_fill, 1);
        check_output("fill_addr", bus.ic_fill_addr, 64'h8000_0000);
        check_output("fill_data", bus.ic_fill_data, 64'h0000_0413);
        check_output("miss_valid", bus.out_valid, 1);
        check_output("miss_inst", bus.out_inst, 64'h0000_0413);
        check_output("miss_pc", bus.out_pc, 64'h8000_0000);
        check_output("miss_fault", bus.out_fault, 0);
        check_output("miss_next_req", bus.ic_req, 1);
        check_output("miss_next_addr", bus.ic_addr, 64'h8000_0004);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("fill_pulse", bus.ic_fill, 0);

        // Queue fills to FQ_DEPTH with the IDU stalled
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 0, 1, 32'h2000 + i, 0, 0, 0, 0);
            check_output("full_req", bus.ic_req, (i < 4) ? 1 : 0);
            next_cycle();
        end
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check_output("full_stall_req", bus.ic_req, 0);
        check_output("full_valid", bus.out_valid, 1);
        check_output("full_pc", bus.out_pc, 64'h8000_0000);
        check_output("full_inst", bus.out_inst, 64'h2001);
        next_cycle();
        apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check_output("full_pop_req", bus.ic_req, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("full_resume_req", bus.ic_req, 1);
        check_output("full_resume_addr", bus.ic_addr, 64'h8000_0010);
        check_output("full_head_pc", bus.out_pc, 64'h8000_0004);
        check_output("full_head_inst", bus.out_inst, 64'h2002);
        next_cycle();

        // Redirect while the address beat is pending
        do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0);
        check_output("ar_redir_arvalid", bus.arvalid, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_output("ar_redir_held", bus.arvalid, 1);
        check_output("ar_redir_araddr", bus.araddr, 64'h8000_0000);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("drop_rready", bus.rready, 1);
        check_output("drop_arvalid", bus.arvalid, 0);
        check_output("drop_no_req", bus.ic_req, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 2'b00, 32'hdead_beef);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("drop_no_push", bus.out_valid, 0);
        check_output("drop_no_fill", bus.ic_fill, 0);
        check_output("drop_rready_off", bus.rready, 0);
        check_output("drop_req", bus.ic_req, 1);
        check_output("drop_addr", bus.ic_addr, 64'h8000_0100);

        // Bus error halts fetch until redirected
        do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_output("err_arvalid", bus.arvalid, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 2'b10, 32'h0000_0bad);
        check_output("err_rready", bus.rready, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("err_valid", bus.out_valid, 1);
        check_output("err_fault", bus.out_fault, 1);
        check_output("err_inst", bus.out_inst, 64'h0000_0bad);
        check_output("err_pc", bus.out_pc, 64'h8000_0000);
        check_output("err_no_fill", bus.ic_fill, 0);
        check_output("err_halt_req", bus.ic_req, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("halt_req", bus.ic_req, 0);
        check_output("halt_arvalid", bus.arvalid, 0);
        next_cycle();
        apply_stimulus(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("halt_flush", bus.out_valid, 0);
        check_output("halt_resume_req", bus.ic_req, 1);
        check_output("halt_resume_addr", bus.ic_addr, 64'h8000_0200);
        next_cycle();

        // Redirect in the same cycle as a pop and a hit push
        do_reset();
        apply_stimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 1, 1, 32'h3000, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(1, 32'h8000_0300, 1, 1, 32'h3001, 0, 0, 0, 0);
        check_output("race_valid_before", bus.out_valid, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check_output("race_empty", bus.out_valid, 0);
        check_output("race_req", bus.ic_req, 1);
        check_output("race_addr", bus.ic_addr, 64'h8000_0300);
        next_cycle();
        apply_stimulus(0, 0, 0, 1, 32'h4000, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("race_head_valid", bus.out_valid, 1);
        check_output("race_head_pc", bus.out_pc, 64'h8000_0300);
        check_output("race_head_inst", bus.out_inst, 64'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_25020037_ifu_pf.md
# ysyx_25020037_ifu_pf

Parametrised prefetching instruction fetch unit: the next-generation fetch stage between the PC/branch logic and the IDU. It walks a sequential fetch PC, looks up the I-cache, falls back to an AXI4-Lite read on miss, refills the cache, and buffers fetched instructions in a FQ_DEPTH-entry queue. The IDU consumes entries through a valid/ready handshake. A redirect flushes the queue and any in-flight fetch.

## Interface
- ADDR_W, 32, address width
- INST_W, 32, instruction/data width
- FQ_DEPTH, 4, fetch-queue entries (power of 2, ≥2)
- RESET_PC, 32'h8000_0000, fetch PC after reset

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  one-cycle redirect/flush request
- redirect_pc  in  ADDR_W  new fetch PC
- out_valid  out  1  queue head valid
- out_ready  in  1  IDU accepts head
- out_pc  out  ADDR_W  head PC
- out_inst  out  INST_W  head instruction
- out_fault  out  1  head is a bus-error entry
- ic_req  out  1  cache lookup request (combinational)
- ic_addr  out  ADDR_W  lookup address
- ic_hit  in  1  hit, valid the cycle after ic_req
- ic_data  in  INST_W  hit data, same cycle as ic_hit
- ic_fill  out  1  one-cycle refill strobe
- ic_fill_addr  out  ADDR_W  refill address
- ic_fill_data  out  INST_W  refill data
- araddr  out  ADDR_W  AXI read address
- arvalid  out  1
- arready  in  1
- rdata  in  INST_W
- rresp  in  2
- rvalid  in  1
- rready  out  1

## Operation
- States: IDLE, LOOKUP, AR, R, DROP, HALT.
- IDLE: if count < FQ_DEPTH, assert ic_req with ic_addr = fetch_pc, go to LOOKUP.
- LOOKUP, ic_hit=1: push {fetch_pc, ic_data, fault=0}, fetch_pc += 4. If count+1 < FQ_DEPTH (pop ignored), assert ic_req for the new PC and stay in LOOKUP. Otherwise go to IDLE.
- LOOKUP, ic_hit=0: load araddr = fetch_pc, go to AR.
- AR: arvalid=1. On arready, go to R.
- R: rready=1. On rvalid with rresp==0: push {fetch_pc, rdata, 0}, pulse ic_fill with that address and data, fetch_pc += 4, go to IDLE.
- R: on rvalid with rresp!=0: push {fetch_pc, rdata, 1}, no fill, go to HALT.
- HALT: issues nothing until a redirect.
- Redirect has priority over every other event in the same cycle:
  - fetch_pc ← redirect_pc and the queue is emptied; any same-cycle push or pop is discarded.
  - From IDLE, LOOKUP, HALT, or R when rvalid arrives in the same cycle: go to IDLE.
  - From AR: arvalid stays high until arready (AXI rule), then go to DROP.
  - From R without rvalid: go to DROP.
- DROP: rready=1. On rvalid, discard the data (no push, no fill) and go to IDLE. A redirect during DROP updates fetch_pc only.
- Queue: circular buffer with log2(FQ_DEPTH)-bit pointers that wrap naturally, plus a count of width log2(FQ_DEPTH)+1.
  - out_valid = (count != 0); head fields are read directly from the buffer.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Push never occurs when full, guaranteed by the issue rules.
- fetch_pc wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - State IDLE, fetch_pc = RESET_PC, queue empty.
  - out_valid, out_fault, ic_req, ic_fill, arvalid, rready all 0.
  - araddr, out_pc, out_inst, ic_fill_addr, ic_fill_data all 0.
- Reset mid-transaction abandons it; no further AXI beats are expected.
- Hit latency: ic_req in cycle N, out_valid in cycle N+2. Sustained hits deliver one instruction per cycle while space remains.
- Miss latency: arvalid in cycle N+2. out_valid and ic_fill are visible the cycle after rvalid.
- arvalid and araddr are registered and stable while arvalid && !arready. rready is registered.
- At most one AXI read is outstanding.
- Redirect in cycle N: out_valid=0 in N+1. ic_req for redirect_pc is asserted no earlier than N+1 (later if draining AR/DROP).

## Test plan
- Reset with RESET_PC=0x8000_0000, all hits, out_ready=1 → ic_addr sequence 0x8000_0000, 0x8000_0004, …; out_pc matches; one out_valid per cycle after a 2-cycle fill.
- Miss at 0x8000_0000, arready after 2 cycles, rvalid 3 cycles later with rdata=0x00000413 → ic_fill=1 with addr 0x8000_0000 and data 0x00000413; out_inst=0x00000413.
- out_ready=0 with FQ_DEPTH=4, all hits → exactly 4 entries pushed, ic_req=0 while full; resumes one cycle after the first pop.
- Redirect to 0x8000_0100 while in AR → arvalid held until arready; the subsequent rvalid is dropped with no push and no fill; next ic_addr = 0x8000_0100.
- rresp=2'b10 on a miss → entry with out_fault=1 and no fill, then no requests; redirect to 0x8000_0200 → fetching resumes there.
- Redirect in the same cycle as a pop and a hit push → queue empty next cycle, count=0.
